// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with a global-stall
// valid/ready handshake; one operand segment resolves per stage.
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_v,
  output logic             o_z
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NB  = SEG / BLK;

  logic             w_en;
  logic [WIDTH-1:0] w_b0;
  logic             w_c0;

  assign w_en    = ~o_valid | i_ready;
  assign o_ready = w_en;
  assign w_b0    = i_b ^ {WIDTH{i_sub}};
  assign w_c0    = i_c ^ i_sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    logic [WIDTH-LO-1:0] w_ain;
    logic [WIDTH-LO-1:0] w_bin;
    logic                w_ci;
    logic                w_vi;
    logic [SEG-1:0]      w_p;
    logic [SEG-1:0]      w_g;
    logic [SEG-1:0]      w_s;
    logic [SEG:0]        w_cc;
    logic [HI-1:0]       w_sum;
    logic                r_v;
    logic                r_c;
    logic [HI-1:0]       r_s;

    if (k == 0) begin : g_in
      assign w_ain = i_a;
      assign w_bin = w_b0;
      assign w_ci  = w_c0;
      assign w_vi  = i_valid;
      assign w_sum = w_s;
    end else begin : g_in
      assign w_ain = g_st[k-1].g_op.r_a;
      assign w_bin = g_st[k-1].g_op.r_b;
      assign w_ci  = g_st[k-1].r_c;
      assign w_vi  = g_st[k-1].r_v;
      assign w_sum = {w_s, g_st[k-1].r_s};
    end

    assign w_p = w_ain[SEG-1:0] ^ w_bin[SEG-1:0];
    assign w_g = w_ain[SEG-1:0] & w_bin[SEG-1:0];

    // Bit carries looked ahead from each block's carry-in;
    // blocks ripple to each other through group G | (P & cin).
    always_comb begin
      logic [SEG:0] c;
      logic         gg;
      logic         pp;
      c    = '0;
      gg   = 1'b0;
      pp   = 1'b1;
      c[0] = w_ci;
      for (int bk = 0; bk < NB; bk++) begin
        for (int j = 1; j <= BLK; j++) begin
          gg = 1'b0;
          pp = 1'b1;
          for (int i = 0; i < j; i++) begin
            gg = w_g[bk*BLK+i] | (w_p[bk*BLK+i] & gg);
            pp = pp & w_p[bk*BLK+i];
          end
          c[bk*BLK+j] = gg | (pp & c[bk*BLK]);
        end
      end
      w_cc = c;
    end

    assign w_s = w_p ^ w_cc[SEG-1:0];

    // Stage register: valid, completed low sum bits, segment carry.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_vi;
        if (w_vi) begin
          r_c <= w_cc[SEG];
          r_s <= w_sum;
        end
      end
    end

    if (k < STAGES - 1) begin : g_op
      logic [WIDTH-HI-1:0] r_a;
      logic [WIDTH-HI-1:0] r_b;

      // Carry forward only the operand bits not yet consumed.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en & w_vi) begin
          r_a <= w_ain[WIDTH-LO-1:SEG];
          r_b <= w_bin[WIDTH-LO-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_fin
      logic r_ov;
      logic r_z;

      // Flags registered alongside the final sum.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_ov <= 1'b0;
          r_z  <= 1'b0;
        end else if (w_en & w_vi) begin
          r_ov <= w_cc[SEG] ^ w_cc[SEG-1];
          r_z  <= ~|w_sum;
        end
      end
    end
  end

  assign o_valid = g_st[STAGES-1].r_v;
  assign o_s     = g_st[STAGES-1].r_s;
  assign o_c     = g_st[STAGES-1].r_c;
  assign o_v     = g_st[STAGES-1].g_fin.r_ov;
  assign o_z     = g_st[STAGES-1].g_fin.r_z;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: three parameter sets, directed and
// random traffic checked against an arithmetic reference model.
module tb_cla_pipe_addsub;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        vo;
    logic        zo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a [3];
  logic [63:0] b [3];
  logic        c [3];
  logic        sub [3];
  logic        iv [3];
  logic        ir [3];
  logic        ordy [3];
  logic        ovld [3];
  logic        oc [3];
  logic        ov [3];
  logic        oz [3];
  logic [31:0] s0;
  logic [63:0] s1;
  logic [15:0] s2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  exp_t q [$];
  int   tq [$];
  logic hold = 1'b0;
  logic [63:0] prev_s;
  logic [2:0]  prev_f;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(32), .BLK(4), .STAGES(2)) u_d0 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[0]), .o_ready(ordy[0]),
    .i_a(a[0][31:0]), .i_b(b[0][31:0]), .i_c(c[0]), .i_sub(sub[0]),
    .o_valid(ovld[0]), .i_ready(ir[0]), .o_s(s0),
    .o_c(oc[0]), .o_v(ov[0]), .o_z(oz[0]));

  cla_pipe_addsub #(.WIDTH(64), .BLK(4), .STAGES(4)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[1]), .o_ready(ordy[1]),
    .i_a(a[1]), .i_b(b[1]), .i_c(c[1]), .i_sub(sub[1]),
    .o_valid(ovld[1]), .i_ready(ir[1]), .o_s(s1),
    .o_c(oc[1]), .o_v(ov[1]), .o_z(oz[1]));

  cla_pipe_addsub #(.WIDTH(16), .BLK(8), .STAGES(1)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[2]), .o_ready(ordy[2]),
    .i_a(a[2][15:0]), .i_b(b[2][15:0]), .i_c(c[2]), .i_sub(sub[2]),
    .o_valid(ovld[2]), .i_ready(ir[2]), .o_s(s2),
    .o_c(oc[2]), .o_v(ov[2]), .o_z(oz[2]));

  function automatic int wof(input int d);
    case (d)
      0: return 32;
      1: return 64;
      default: return 16;
    endcase
  endfunction

  function automatic int stg(input int d);
    case (d)
      0: return 2;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] os(input int d);
    case (d)
      0: return {32'b0, s0};
      1: return s1;
      default: return {48'b0, s2};
    endcase
  endfunction

  // Integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t ref_model(input int w, input logic [63:0] x,
                                     input logic [63:0] y, input logic ci,
                                     input logic sb);
    logic [64:0] one;
    logic [63:0] m;
    logic signed [67:0] ua, ub, sa, sy, cc, r, sr, hi, lo, top;
    exp_t e;
    one = 65'd1;
    m   = 64'((one << w) - 65'd1);
    ua  = $signed({4'b0, x & m});
    ub  = $signed({4'b0, y & m});
    cc  = $signed({67'b0, ci});
    top = 68'sd1 <<< w;
    sa  = x[w-1] ? ua - top : ua;
    sy  = y[w-1] ? ub - top : ub;
    hi  = (68'sd1 <<< (w - 1)) - 68'sd1;
    lo  = -(68'sd1 <<< (w - 1));
    if (!sb) begin
      r    = ua + ub + cc;
      sr   = sa + sy + cc;
      e.co = (r >= top);
    end else begin
      r    = ua - ub - cc;
      sr   = sa - sy - cc;
      e.co = (ua >= ub + cc);
    end
    e.s  = r[63:0] & m;
    e.vo = (sr > hi) || (sr < lo);
    e.zo = (e.s == 64'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int d, input bit lat, output bit acc);
    exp_t e;
    int   t;
    #1;
    if (hold) begin
      chk("stable_s", os(d), prev_s);
      chk("stable_f", {oc[d], ov[d], oz[d]}, prev_f);
    end
    chk("o_ready", ordy[d], !(ovld[d] && !ir[d]));
    acc = iv[d] && ordy[d];
    if (ovld[d] && ir[d]) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL spurious: observed o_valid=1 expected no pending result");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        t = tq.pop_front();
        n_out++;
        chk("o_s", os(d), e.s);
        chk("o_c", oc[d], e.co);
        chk("o_v", ov[d], e.vo);
        chk("o_z", oz[d], e.zo);
        if (lat) chk("latency", cyc - t, stg(d));
      end
    end
    if (acc) begin
      q.push_back(ref_model(wof(d), a[d], b[d], c[d], sub[d]));
      tq.push_back(cyc);
    end
    hold   = ovld[d] && !ir[d];
    prev_s = os(d);
    prev_f = {oc[d], ov[d], oz[d]};
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int d, input bit lat);
    bit acc;
    iv[d] = 1'b0;
    ir[d] = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) step(d, lat, acc);
    chk("drain", q.size(), 0);
  endtask

  task automatic issue(input int d, input logic [63:0] ta,
                       input logic [63:0] tb, input logic tc,
                       input logic ts);
    bit acc;
    a[d]   = ta;
    b[d]   = tb;
    c[d]   = tc;
    sub[d] = ts;
    iv[d]  = 1'b1;
    ir[d]  = 1'b1;
    step(d, 1'b1, acc);
    chk("accept", acc, 1);
    drain(d, 1'b1);
  endtask

  task automatic rnd(input int d);
    a[d]   = {$urandom, $urandom};
    b[d]   = ($urandom_range(0, 15) == 0) ? a[d] : {$urandom, $urandom};
    c[d]   = 1'($urandom_range(0, 1));
    sub[d] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent;
    int n0;
    for (int d = 0; d < 3; d++) begin
      a[d] = '0; b[d] = '0; c[d] = 1'b0; sub[d] = 1'b0;
      iv[d] = 1'b0; ir[d] = 1'b1;
    end
    rst   = 1'b1;
    iv[0] = 1'b1;
    ir[0] = 1'b0;
    rnd(0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    iv[0] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", ovld[d], 0);
      chk("rst_s", os(d), 0);
      chk("rst_flags", {oc[d], ov[d], oz[d]}, 0);
      chk("rst_ready", ordy[d], 1);
    end
    ir[0] = 1'b1;

    issue(0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
    issue(0, 64'h8000_0000, 64'h1, 1'b0, 1'b1);
    issue(0, 64'h5, 64'h5, 1'b1, 1'b1);
    issue(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0);
    issue(0, 64'h0, 64'h0, 1'b1, 1'b1);
    issue(0, 64'h1234, 64'h1234, 1'b0, 1'b1);

    rnd(0);
    iv[0] = 1'b1;
    step(0, 1'b1, acc);
    rnd(0);
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst   = 1'b0;
    iv[0] = 1'b0;
    q.delete();
    tq.delete();
    hold = 1'b0;
    chk("rst_mid", ovld[0], 0);
    repeat (5) step(0, 1'b0, acc);

    for (int i = 0; i < 50; i++) begin
      rnd(0);
      iv[0] = 1'b1;
      step(0, 1'b1, acc);
    end
    drain(0, 1'b1);

    sent = 0;
    n0   = n_out;
    rnd(0);
    for (int i = 0; i < 200 && (sent < 10 || q.size() != 0); i++) begin
      if (i < 3) ir[0] = 1'b1;
      else if (i <= 7) ir[0] = 1'b0;
      else ir[0] = 1'($urandom_range(0, 1));
      iv[0] = (sent < 10);
      if (i == 5) chk("held", q.size(), stg(0));
      step(0, 1'b0, acc);
      if (acc) begin
        sent++;
        rnd(0);
      end
    end
    chk("bp_sent", sent, 10);
    chk("bp_count", n_out - n0, 10);
    drain(0, 1'b0);

    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        rnd(d);
        iv[d] = ($urandom_range(0, 7) != 0);
        step(d, 1'b1, acc);
      end
      drain(d, 1'b1);
      issue(d, '1, '1, 1'b1, 1'b0);
      issue(d, '1, '1, 1'b1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. Operands of WIDTH bits are split into STAGES equal segments. Each segment is built from BLK-bit lookahead blocks rippled block-to-block, and one segment resolves per pipeline stage. This makes the 32-bit datapath adder timing-closable at full clock rate. The block sits between operand registers and the ALU result mux, and adds subtract mode, overflow/zero flags and backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES*BLK.
- BLK, 4, bits per lookahead block (group P/G over BLK bits).
- STAGES, 2, pipeline stages = latency in cycles; 1..WIDTH/BLK.

- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept input this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_c  in  1  carry-in (add) / borrow-in (sub).
- i_sub  in  1  0: add, 1: subtract.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_s  out  WIDTH  sum/difference.
- o_c  out  1  raw carry-out of MSB adder bit.
- o_v  out  1  signed (two's complement) overflow.
- o_z  out  1  o_s == 0.

## Operation
- Add: {o_c,o_s} = i_a + i_b + i_c.
- Sub: effective B = ~i_b, carry-in = ~i_c, so o_s = i_a - i_b - i_c mod 2^WIDTH. o_c = 1 means no borrow.
- o_v = carry into MSB XOR carry out of MSB.
- o_z = ~|o_s, computed in the final stage from final o_s.
- Segment k (bits [(k+1)*SEG-1 : k*SEG], SEG = WIDTH/STAGES):
  - Computed in stage k from the registered segment carry of stage k-1 (stage 0 uses the effective carry-in).
  - Within a segment, carries between BLK blocks ripple via group G | (P & cin).
  - Within a block, bit carries come from p/g lookahead.
- Stage registers:
  - Stage k holds: valid bit, completed low sum bits [0..(k+1)*SEG-1], segment carry-out, MSB-carry-in (final stage only), and the not-yet-used operand bits (effective B already inverted).
  - Operand bits are dropped once consumed.
- Flow control is a global stall:
  - en = ~o_valid | i_ready; o_ready = en.
  - When en=1, every stage register loads from its predecessor. Stage 0 loads i_valid and operands.
  - When en=0, all stage registers hold.
  - Bubbles are not compressed while stalled.
- Transfer in: i_valid & o_ready. Transfer out: o_valid & i_ready.
- o_s/o_c/o_v/o_z are registered outputs of the final stage and stay stable while o_valid & ~i_ready.
- i_a/i_b/i_c/i_sub are sampled only on an input transfer; they are ignored otherwise.
- Reset:
  - All valid bits 0; o_valid=0; o_s=0, o_c=0, o_v=0, o_z=0; o_ready=1 during the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight results; no result is emitted for them.
- STAGES=1 degenerates to a single registered stage with a full-width block chain.

## Timing
- Latency: input accepted at edge N produces o_valid=1 after edge N+STAGES-1, i.e. visible in cycle N+STAGES (registered after STAGES edges).
- Throughput: one result per cycle while i_ready=1.
- o_ready is combinational from o_valid and i_ready only; it has no path from i_valid.
- Simultaneous output transfer and input transfer in the same cycle is allowed and required: full throughput with the pipeline full.
- i_ready low for M cycles with the pipeline full:
  - Exactly STAGES results are held; none are lost or duplicated.
  - o_ready=0 for those M cycles.
- Critical path per stage: one SEG-bit segment (SEG/BLK block hops) plus the stage mux.

## Test plan
- Reset: assert i_rst 2 cycles with i_valid=1. Required: o_valid=0, o_s=0, o_c=o_v=o_z=0, and o_ready=1 on the first cycle after release.
- Add, defaults: a=0xFFFF_FFFF, b=0x0000_0001, c=0. Required: o_s=0, o_c=1, o_v=0, o_z=1, with o_valid exactly 2 cycles after acceptance.
- Sub/overflow: sub=1, a=0x8000_0000, b=1, c=0. Required: o_s=0x7FFF_FFFF, o_c=1, o_v=1.
- Sub with borrow: sub=1, a=5, b=5, c=1. Required: o_s=0xFFFF_FFFF, o_c=0, o_z=0.
- Backpressure:
  - Stream 10 random operand pairs back-to-back.
  - Hold i_ready=0 for cycles 3-7, and toggle i_ready randomly afterwards.
  - Required: 10 results in order, each matching the reference a±b±c.
  - Outputs stable while stalled; o_ready=0 only when o_valid & ~i_ready.
- Parameter sweep:
  - Run WIDTH=64/BLK=4/STAGES=4 and WIDTH=16/BLK=8/STAGES=1, each with 1000 random add/sub vectors plus a=b=all-ones, c=1.
  - Required: all flags correct and latency = STAGES.
